sc_statemachine_pointtype_ctrl: RTL

Command generator for the point-type position register: turns raw active-low player buttons and a crash flag into the one-cycle `clear`, `load0` and `shiftselection` strobes that the register consumes. It is the initiator side of that register's command interface. One instance drives one register channel; the top level instantiates two for the two channels.

---
 rtl/sc_pointtype_pkg.sv | 33 +++
 rtl/sc_sync2.sv | 25 ++
 rtl/sc_statemachine_pointtype_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sc_pointtype_pkg.sv
// Shared definitions for the point-type position register command interface:
// controller state encodings, shift command codes and the output decode.
package sc_pointtype_pkg;

  typedef enum logic [2:0] {
    RESET = 3'd0,
    CLEAR = 3'd1,
    CHECK = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4,
    HOLD  = 3'd5,
    CRASH = 3'd6,
    LOCK  = 3'd7
  } ptState_t;

  localparam logic [1:0] SHIFT_NONE  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  // Moore decode: {clear_OutLow, load0_OutLow, shiftselection}
  function automatic logic [3:0] decodeOutputs(input ptState_t st);
    logic [3:0] outs;
    case (st)
      CLEAR:   outs = {1'b0, 1'b1, SHIFT_NONE};
      CRASH:   outs = {1'b1, 1'b0, SHIFT_NONE};
      LEFT:    outs = {1'b1, 1'b1, SHIFT_LEFT};
      RIGHT:   outs = {1'b1, 1'b1, SHIFT_RIGHT};
      default: outs = {1'b1, 1'b1, SHIFT_NONE};
    endcase
    return outs;
  endfunction

endpackage

// File: rtl/sc_sync2.sv
// Two-flop synchronizer for one asynchronous input; both flops take RESET_VAL
// while reset is asserted.
module sc_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic asyncIn,
  output logic syncOut
);

  logic metaReg;

  // Capture stage followed by the settled output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      metaReg <= RESET_VAL;
      syncOut <= RESET_VAL;
    end else begin
      metaReg <= asyncIn;
      syncOut <= metaReg;
    end
  end

endmodule

// File: rtl/sc_statemachine_pointtype_ctrl.sv
// Command generator for one point-type register channel: turns buttons and the
// crash flag into one-cycle clear / load0 / shift strobes.
module sc_statemachine_pointtype_ctrl
  import sc_pointtype_pkg::*;
#(
  parameter int REPEAT_TICKS = 12500000,
  parameter int CNT_WIDTH    = 24
) (
  input  logic       SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic       SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic       SC_STATEMACHINEPOINT_left_InLow,
  input  logic       SC_STATEMACHINEPOINT_right_InLow,
  input  logic       SC_STATEMACHINEPOINT_start_InLow,
  input  logic       SC_STATEMACHINEPOINT_crash_InLow,
  output logic       SC_STATEMACHINEPOINT_clear_OutLow,
  output logic       SC_STATEMACHINEPOINT_load0_OutLow,
  output logic [1:0] SC_STATEMACHINEPOINT_shiftselection_Out
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(REPEAT_TICKS - 1);

  logic clk;
  logic rst;
  logic leftSync;
  logic rightSync;
  logic startSync;

  ptState_t stateReg;
  ptState_t stateNext;
  logic [CNT_WIDTH-1:0] holdCnt;
  logic dirRight;
  logic resetDone;

  logic leftPressed;
  logic rightPressed;
  logic startPressed;
  logic crashActive;
  logic latchedHeld;

  assign clk = SC_STATEMACHINEPOINT_CLOCK_50;
  assign rst = SC_STATEMACHINEPOINT_RESET_InHigh;

  sc_sync2 #(.RESET_VAL(1'b1)) uSyncLeft (
    .clk(clk), .rst(rst), .asyncIn(SC_STATEMACHINEPOINT_left_InLow), .syncOut(leftSync)
  );
  sc_sync2 #(.RESET_VAL(1'b1)) uSyncRight (
    .clk(clk), .rst(rst), .asyncIn(SC_STATEMACHINEPOINT_right_InLow), .syncOut(rightSync)
  );
  sc_sync2 #(.RESET_VAL(1'b1)) uSyncStart (
    .clk(clk), .rst(rst), .asyncIn(SC_STATEMACHINEPOINT_start_InLow), .syncOut(startSync)
  );

  assign leftPressed  = ~leftSync;
  assign rightPressed = ~rightSync;
  assign startPressed = ~startSync;
  assign crashActive  = ~SC_STATEMACHINEPOINT_crash_InLow;
  // Only the latched button keeps HOLD alive; the opposite one is ignored
  assign latchedHeld  = dirRight ? rightPressed : leftPressed;

  // Next-state selection, crash taking priority over start over direction
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      RESET: begin
        if (resetDone) stateNext = CLEAR;
        else           stateNext = RESET;
      end
      CLEAR: stateNext = CHECK;
      CHECK: begin
        if (crashActive)                       stateNext = CRASH;
        else if (startPressed)                 stateNext = CLEAR;
        else if (leftPressed && !rightPressed) stateNext = LEFT;
        else if (rightPressed && !leftPressed) stateNext = RIGHT;
        else                                   stateNext = CHECK;
      end
      LEFT:  stateNext = HOLD;
      RIGHT: stateNext = HOLD;
      HOLD: begin
        if (crashActive)            stateNext = CRASH;
        else if (startPressed)      stateNext = CLEAR;
        else if (!latchedHeld)      stateNext = CHECK;
        else if (holdCnt == CNT_LAST) begin
          if (dirRight) stateNext = RIGHT;
          else          stateNext = LEFT;
        end else                    stateNext = HOLD;
      end
      CRASH: stateNext = LOCK;
      LOCK: begin
        if (startPressed) stateNext = CLEAR;
        else              stateNext = LOCK;
      end
      default: stateNext = RESET;
    endcase
  end

  // State, hold counter, direction latch and outputs registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg  <= RESET;
      resetDone <= 1'b0;
      holdCnt   <= CNT_ZERO;
      dirRight  <= 1'b0;
      SC_STATEMACHINEPOINT_clear_OutLow       <= 1'b1;
      SC_STATEMACHINEPOINT_load0_OutLow       <= 1'b1;
      SC_STATEMACHINEPOINT_shiftselection_Out <= SHIFT_NONE;
    end else begin
      stateReg  <= stateNext;
      resetDone <= 1'b1;
      case (stateReg)
        LEFT: begin
          holdCnt  <= CNT_ZERO;
          dirRight <= 1'b0;
        end
        RIGHT: begin
          holdCnt  <= CNT_ZERO;
          dirRight <= 1'b1;
        end
        HOLD:    holdCnt <= holdCnt + CNT_ONE;
        default: holdCnt <= holdCnt;
      endcase
      {SC_STATEMACHINEPOINT_clear_OutLow,
       SC_STATEMACHINEPOINT_load0_OutLow,
       SC_STATEMACHINEPOINT_shiftselection_Out} <= decodeOutputs(stateNext);
    end
  end

endmodule
